// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared constants and helpers for the BCD counter family.
//   DIGIT_W      width of one BCD decade
//   DIGIT_MAX    largest legal BCD digit value
//   bcd_clamp    limits a 4-bit value to the legal 0..9 range
//   is_valid_bcd true when a 4-bit value is a legal BCD digit
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] digit);
        return (digit > DIGIT_MAX) ? DIGIT_MAX : digit;
    endfunction

    function automatic logic is_valid_bcd(input logic [DIGIT_W-1:0] digit);
        return (digit <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One BCD decade register (0..9) with clear, clamped parallel load and a
// single up/down step per cycle.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   clear        synchronous clear to 0 (highest priority)
//   load         synchronous load of load_digit, clamped to 9
//   load_digit   digit value presented for a load
//   step_in      carry (up) or borrow (down) request from the lower decade
//   up_dn        1 = step up, 0 = step down
//   q_digit      registered digit value
//   step_out     carry/borrow into the next decade; combinational
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               step_in,
    input  logic               up_dn,
    output logic [DIGIT_W-1:0] q_digit,
    output logic               step_out
);

    logic at_limit;

    // The limit depends on direction: 9 rolls over going up, 0 going down.
    assign at_limit = up_dn ? (q_digit == DIGIT_MAX) : (q_digit == '0);
    assign step_out = step_in & at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_digit <= '0;
        end else if (clear) begin
            q_digit <= '0;
        end else if (load) begin
            q_digit <= bcd_clamp(load_digit);
        end else if (step_in) begin
            if (up_dn) begin
                q_digit <= at_limit ? '0 : q_digit + 4'd1;
            end else begin
                q_digit <= at_limit ? DIGIT_MAX : q_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter
// NUM_DIGITS cascaded BCD decades counting up or down, with synchronous
// clear, validated parallel load, and wrap or saturate at the range limits.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   en         count enable, one step per cycle
//   up_dn      1 = count up, 0 = count down
//   clear      synchronous clear (priority over load and en)
//   load       synchronous parallel load (priority over en)
//   load_val   BCD load value, digit i in bits [4i+3:4i]
//   q          registered BCD count
//   done       combinational: q at all 9s (up) or all 0s (down)
//   wrap       one-cycle pulse: count wrapped, or a saturated step was blocked
//   load_err   one-cycle pulse: a load contained a digit above 9
module bcd_multi_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] q,
    output logic                          done,
    output logic                          wrap,
    output logic                          load_err
);

    // step[i] is the carry/borrow into decade i; step[NUM_DIGITS] leaves the top.
    logic [NUM_DIGITS:0]   step;
    logic [NUM_DIGITS-1:0] digit_bad;
    logic                  all_nine;
    logic                  all_zero;
    logic                  wrap_hit;
    logic                  any_bad;

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (q[DIGIT_W*i +: DIGIT_W] != DIGIT_MAX) all_nine = 1'b0;
            if (q[DIGIT_W*i +: DIGIT_W] != '0)        all_zero = 1'b0;
        end
    end

    assign done = up_dn ? all_nine : all_zero;

    // In saturate mode a step at the limit is simply never injected, so the
    // whole chain holds without any per-digit knowledge of the mode.
    assign step[0] = en & ~(SATURATE & done);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear),
            .load       (load),
            .load_digit (load_val[DIGIT_W*g +: DIGIT_W]),
            .step_in    (step[g]),
            .up_dn      (up_dn),
            .q_digit    (q[DIGIT_W*g +: DIGIT_W]),
            .step_out   (step[g+1])
        );
        assign digit_bad[g] = ~is_valid_bcd(load_val[DIGIT_W*g +: DIGIT_W]);
    end

    assign any_bad = |digit_bad;

    // Wrapping: the carry out of the top decade. Saturating: a step requested
    // while already at the limit (it was suppressed above).
    assign wrap_hit = SATURATE ? (en & done) : step[NUM_DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (clear) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            wrap     <= 1'b0;
            load_err <= any_bad;
        end else begin
            wrap     <= wrap_hit;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter
// Directed bench for a 3-decade counter, built once wrapping and once
// saturating, both driven from the same inputs.
module tb_bcd_multi_counter;

    localparam int ND = 3;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, clear, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q0, q1;
    logic         done0, done1, wrap0, wrap1, err0, err1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_multi_counter #(.NUM_DIGITS(ND), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .q(q0), .done(done0),
        .wrap(wrap0), .load_err(err0)
    );

    bcd_multi_counter #(.NUM_DIGITS(ND), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .q(q1), .done(done1),
        .wrap(wrap1), .load_err(err1)
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = '0;
        tick(); tick();
        checks++; if (q0 !== 12'h000) $display("FAIL reset_q got=%h exp=000", q0); else passed++;
        checks++; if (wrap0 !== 1'b0 || wrap1 !== 1'b0) $display("FAIL reset_wrap got=%b%b exp=00", wrap0, wrap1); else passed++;
        checks++; if (err0 !== 1'b0) $display("FAIL reset_err got=%b exp=0", err0); else passed++;
        checks++; if (done0 !== 1'b0) $display("FAIL reset_done_up got=%b exp=0", done0); else passed++;
        up_dn = 1'b0; #1;
        checks++; if (done0 !== 1'b1) $display("FAIL reset_done_dn got=%b exp=1", done0); else passed++;
        up_dn = 1'b1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_count_up();
        int exp_v = 0;
        int wraps = 0;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            exp_v = (exp_v + 1) % 1000;
            if (wrap0) wraps++;
            checks++;
            if (q0 !== to_bcd(exp_v) || wrap0 !== (exp_v == 0) || done0 !== (exp_v == 999)) begin
                $display("FAIL count_up step=%0d got q=%h wrap=%b done=%b exp q=%h wrap=%b done=%b",
                         i, q0, wrap0, done0, to_bcd(exp_v), exp_v == 0, exp_v == 999);
            end else passed++;
        end
        checks++; if (wraps != 1) $display("FAIL count_up_wraps got=%0d exp=1", wraps); else passed++;
    endtask

    task automatic test_wrap_down();
        up_dn = 1'b0; #1;
        checks++; if (done0 !== 1'b1) $display("FAIL down_done0 got=%b exp=1", done0); else passed++;
        tick();
        checks++; if (q0 !== 12'h999 || wrap0 !== 1'b1) $display("FAIL down_wrap got q=%h wrap=%b exp q=999 wrap=1", q0, wrap0); else passed++;
        tick();
        checks++; if (q0 !== 12'h998 || wrap0 !== 1'b0) $display("FAIL down_next got q=%h wrap=%b exp q=998 wrap=0", q0, wrap0); else passed++;
        en = 1'b0;
        tick();
        checks++; if (q0 !== 12'h998 || wrap0 !== 1'b0) $display("FAIL hold got q=%h wrap=%b exp q=998 wrap=0", q0, wrap0); else passed++;
    endtask

    task automatic test_saturate();
        load = 1'b1; load_val = 12'h999; up_dn = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        checks++; if (done1 !== 1'b1) $display("FAIL sat_done got=%b exp=1", done1); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q1 !== 12'h999 || wrap1 !== 1'b1)
                $display("FAIL sat_hold cyc=%0d got q=%h wrap=%b exp q=999 wrap=1", i, q1, wrap1);
            else passed++;
        end
        up_dn = 1'b0;
        tick();
        checks++; if (q1 !== 12'h998 || wrap1 !== 1'b0) $display("FAIL sat_reverse got q=%h wrap=%b exp q=998 wrap=0", q1, wrap1); else passed++;
        en = 1'b0;
    endtask

    task automatic test_load_err();
        load = 1'b1; load_val = 12'h1A9;
        tick();
        checks++; if (q0 !== 12'h199 || err0 !== 1'b1) $display("FAIL load_clamp got q=%h err=%b exp q=199 err=1", q0, err0); else passed++;
        load_val = 12'h123;
        tick();
        checks++; if (q0 !== 12'h123 || err0 !== 1'b0) $display("FAIL load_ok got q=%h err=%b exp q=123 err=0", q0, err0); else passed++;
        load_val = 12'hF0B;
        tick();
        checks++; if (q0 !== 12'h909 || err0 !== 1'b1) $display("FAIL load_clamp2 got q=%h err=%b exp q=909 err=1", q0, err0); else passed++;
        load = 1'b0;
        tick();
        checks++; if (err0 !== 1'b0) $display("FAIL err_pulse got=%b exp=0", err0); else passed++;
    endtask

    task automatic test_priority();
        clear = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 12'h555;
        tick();
        checks++; if (q0 !== 12'h000) $display("FAIL prio_clear got=%h exp=000", q0); else passed++;
        clear = 1'b0;
        tick();
        checks++; if (q0 !== 12'h555) $display("FAIL prio_load got=%h exp=555", q0); else passed++;
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_ripple_reset();
        load = 1'b1; load_val = 12'h099;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++; if (q0 !== 12'h100) $display("FAIL ripple got=%h exp=100", q0); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (q0 !== 12'h000 || wrap0 !== 1'b0) $display("FAIL async_rst got q=%h wrap=%b exp q=000 wrap=0", q0, wrap0); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (q0 !== 12'h001) $display("FAIL resume got=%h exp=001", q0); else passed++;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_down();
        test_saturate();
        test_load_err();
        test_priority();
        test_ripple_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bcd_multi_counter.md
Name: bcd_multi_counter

Overview:
Parametrised multi-decade BCD counter: NUM_DIGITS cascaded decades, each counting 0-9. Supports up/down counting, synchronous clear, parallel load with digit validation, and wrap or saturate at the range limits. Serves timers, event counters and display-driver front ends. Replaces single-decade counters chained by hand.

Parameters:
NUM_DIGITS, 4, number of BCD decades (>=1); count range 0 .. 10^NUM_DIGITS-1
SATURATE, 0, 0 = wrap at the range limits; 1 = hold at the range limits

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
en  in  1  count enable; one step per cycle while high
up_dn  in  1  1 = count up, 0 = count down; sampled with en
clear  in  1  synchronous clear to zero
load  in  1  synchronous parallel load
load_val  in  4*NUM_DIGITS  BCD load value; digit i = bits [4i+3:4i], digit 0 = least significant
q  out  4*NUM_DIGITS  current BCD count (registered)
done  out  1  combinational; high when q is at the terminal value for the current up_dn (all 9s if up, all 0s if down)
wrap  out  1  registered one-cycle pulse when the count wrapped (SATURATE=0) or a step was blocked (SATURATE=1)
load_err  out  1  registered one-cycle pulse when a load contained any digit >9

Behaviour:
- Reset (rst=1, asynchronous): q=0, wrap=0, load_err=0. Takes effect immediately and holds until rst falls. Reset mid-count discards the count with no residual pulses.
- Priority each cycle: clear > load > en. Lower-priority actions are ignored in that cycle.
- clear=1: q<=0 next edge; wrap<=0; load_err<=0.
- load=1: each digit of q <= load_val digit, except any digit >9 is clamped to 9. load_err<=1 if any digit was clamped, else 0. wrap<=0.
- en=1 with up_dn=1: add 1 to digit 0.
  - A digit that would exceed 9 becomes 0 and carries into the next digit.
  - Carries ripple combinationally through all digits within the same cycle.
- en=1 with up_dn=0: subtract 1 from digit 0.
  - A digit that would go below 0 becomes 9 and borrows from the next digit.
- Range limits, up: at all 9s with SATURATE=0, q<=0 and wrap<=1. With SATURATE=1, q holds and wrap<=1.
- Range limits, down: at all 0s with SATURATE=0, q<=all 9s and wrap<=1. With SATURATE=1, q holds and wrap<=1.
- en=0 with no clear/load: q holds, wrap<=0, load_err<=0.
- wrap and load_err are single-cycle pulses. They deassert on the next edge unless the triggering condition recurs; continuous en at the limit with SATURATE=1 keeps wrap high.
- Latency: q updates on the edge after the controlling input is sampled. done reflects q and up_dn combinationally, so it has zero latency versus q.
- Invariant: every digit of q is 0..9 at all times after reset.
- up_dn may change any cycle. Direction reversal needs no dead cycle.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4 and DIGIT_MAX=4'd9 constants.
  - Function bcd_clamp (digit, returns min(digit,9)).
  - Function is_valid_bcd.
- Sub-module bcd_digit: one decade register. Ports: clk, rst, clear, load, load_digit, step_in (carry/borrow in), up_dn, q_digit, step_out.
  - step_out = step_in & (up_dn ? q_digit==9 : q_digit==0).
  - Instantiated NUM_DIGITS times via generate.
- Top level adds:
  - the en gating into digit 0;
  - SATURATE blocking, by suppressing step_in to digit 0 when done is high;
  - the wrap and load_err pulse registers.

Test Plan:
- NUM_DIGITS=3, reset, en=1, up_dn=1 for 1000 cycles -> q steps 000..999. After 1000 steps q=000 and wrap pulses exactly once. done is high only while q=999.
- From q=000, en=1, up_dn=0, SATURATE=0 -> next q=999 with wrap=1. Next cycle q=998 with wrap=0.
- SATURATE=1: load 999, then en=1, up_dn=1 for 3 cycles -> q stays 999 and wrap is high all 3 cycles. Switch up_dn=0 -> q=998.
- load_val=0x1A9 (middle digit 0xA) with load=1 -> q=199 and load_err=1 for one cycle. Then load 0x123 -> q=123 and load_err=0.
- Same cycle: clear=1, load=1, en=1 -> q=000. Then load=1 and en=1 together -> q=load_val with no increment.
- Ripple and reset: q=099, en=1, up_dn=1 -> q=100. Assert rst mid-cycle -> q=000 immediately, before the next clk edge. Release rst -> counting resumes from 000.
